// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC register, single-outstanding instruction fetch, IF/ID register with a one-entry skid.
// Latency: id_valid rises one cycle after imem_rvalid; the next fetch issues the cycle after rvalid.
// Backpressure: id_ready low parks one returned word in the skid; fetch stalls while skid is full or a request is in flight.
//
// Ports: clk, rst_n (async, active-low)
//        imem_req/imem_addr out, imem_rvalid/imem_rdata in  -- instruction memory side
//        redirect_valid/redirect_pc in                      -- branch flush from later stages
//        id_valid/id_instr/id_op/id_pc out, id_ready in     -- decode side
module if_id_fetch_stage #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [31:0]         id_instr,
    output logic [10:0]         id_op,
    output logic [PC_WIDTH-1:0] id_pc
);

    logic [PC_WIDTH-1:0] pcQ;
    logic [PC_WIDTH-1:0] reqPcQ;
    logic                outstandingQ;
    logic                dropQ;
    logic                skidValidQ;
    logic [31:0]         skidInstrQ;
    logic [PC_WIDTH-1:0] skidPcQ;
    logic                idValidQ;
    logic [31:0]         idInstrQ;
    logic [PC_WIDTH-1:0] idPcQ;

    logic respValid;
    logic outFree;

    // rst_n is folded in so the strobe drops the instant reset asserts.
    // A redirect suppresses issue so the stale PC never reaches memory.
    assign imem_req  = rst_n & ~outstandingQ & ~skidValidQ & ~redirect_valid;
    assign imem_addr = pcQ;

    // Responses with nothing in flight are stray and ignored.
    assign respValid = imem_rvalid & outstandingQ;
    assign outFree   = ~idValidQ | id_ready;

    assign id_valid = idValidQ;
    assign id_instr = idInstrQ;
    assign id_pc    = idPcQ;
    assign id_op    = idInstrQ[31:21];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcQ          <= RESET_PC;
            reqPcQ       <= '0;
            outstandingQ <= 1'b0;
            dropQ        <= 1'b0;
            skidValidQ   <= 1'b0;
            skidInstrQ   <= '0;
            skidPcQ      <= '0;
            idValidQ     <= 1'b0;
            idInstrQ     <= '0;
            idPcQ        <= '0;
        end else if (redirect_valid) begin
            // Flush overrides every same-cycle load, including a skid drain.
            pcQ        <= redirect_pc;
            idValidQ   <= 1'b0;
            skidValidQ <= 1'b0;
            if (outstandingQ) begin
                if (imem_rvalid) begin
                    // The in-flight word lands now and is thrown away here,
                    // so nothing is left to drop later.
                    outstandingQ <= 1'b0;
                    dropQ        <= 1'b0;
                end else begin
                    // Word still in flight: remember to discard it on arrival.
                    dropQ <= 1'b1;
                end
            end
        end else begin
            if (imem_req) begin
                outstandingQ <= 1'b1;
                reqPcQ       <= pcQ;
                pcQ          <= pcQ + PC_WIDTH'(4);
            end
            if (respValid) begin
                outstandingQ <= 1'b0;
                dropQ        <= 1'b0;
            end

            // Skid and a fresh response are never both present: issue
            // waits for the skid to empty.
            if (skidValidQ && id_ready) begin
                idInstrQ   <= skidInstrQ;
                idPcQ      <= skidPcQ;
                idValidQ   <= 1'b1;
                skidValidQ <= 1'b0;
            end else if (respValid && !dropQ) begin
                if (outFree) begin
                    idInstrQ <= imem_rdata;
                    idPcQ    <= reqPcQ;
                    idValidQ <= 1'b1;
                end else begin
                    skidInstrQ <= imem_rdata;
                    skidPcQ    <= reqPcQ;
                    skidValidQ <= 1'b1;
                end
            end else if (idValidQ && id_ready) begin
                idValidQ <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_instr;
    logic [10:0]   id_op;
    logic [PW-1:0] id_pc;

    if_id_fetch_stage #(
        .PC_WIDTH (PW),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_op          (id_op),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory contents: two fixed words, elsewhere opcode = addr[12:2].
    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == 64'h0)      return 32'hF840_0000;
        else if (a == 64'h4) return 32'h8B00_0000;
        else                 return {a[12:2], 21'h0A5A5A};
    endfunction

    // Memory model: a request seen in cycle c returns in cycle c+memLat.
    // Updates at negedge+2, clear of the checks at negedge+1.
    int          memLat    = 1;
    int          memCnt    = 0;
    logic        memPend   = 1'b0;
    logic [63:0] memAddr   = '0;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata  = '0;
    logic        manRvalid = 1'b0;
    logic [31:0] manRdata  = '0;

    assign imem_rvalid = memRvalid | manRvalid;
    assign imem_rdata  = manRvalid ? manRdata : memRdata;

    always @(negedge clk) begin
        #2;
        memRvalid = 1'b0;
        if (!rst_n) begin
            memPend = 1'b0;
        end else begin
            if (memPend) begin
                memCnt--;
                if (memCnt == 0) begin
                    memRvalid = 1'b1;
                    memRdata  = memWord(memAddr);
                    memPend   = 1'b0;
                end
            end
            if (imem_req) begin
                memPend = 1'b1;
                memCnt  = memLat;
                memAddr = imem_addr;
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        expReq;
        logic [63:0] expAddr;
        logic        expVld;
        logic [10:0] expOp;
        logic [63:0] expPc;
    } vec_t;

    vec_t tbl[$];

    function automatic void addVec(input logic rdy, input logic req, input logic [63:0] addr,
                                   input logic vld, input logic [10:0] op, input logic [63:0] pc);
        vec_t v;
        v.rdy = rdy; v.expReq = req; v.expAddr = addr;
        v.expVld = vld; v.expOp = op; v.expPc = pc;
        tbl.push_back(v);
    endfunction

    task automatic doReset(input int lat);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        manRvalid      = 1'b0;
        memLat         = lat;
        repeat (3) @(posedge clk);
    endtask

    // Each entry is one cycle after reset release (entry 0 = cycle 1).
    task automatic runTable(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n          = 1'b1;
            redirect_valid = 1'b0;
            id_ready       = tbl[i].rdy;
            #1;
            chk($sformatf("%s c%0d imem_req", tag, i + 1), imem_req, tbl[i].expReq);
            if (tbl[i].expReq)
                chk($sformatf("%s c%0d imem_addr", tag, i + 1), imem_addr, tbl[i].expAddr);
            chk($sformatf("%s c%0d id_valid", tag, i + 1), id_valid, tbl[i].expVld);
            if (tbl[i].expVld) begin
                chk($sformatf("%s c%0d id_op", tag, i + 1), id_op, tbl[i].expOp);
                chk($sformatf("%s c%0d id_pc", tag, i + 1), id_pc, tbl[i].expPc);
            end
        end
        tbl.delete();
    endtask

    task automatic cyc();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        doReset(1);
        #1;
        chk("reset imem_req", imem_req, 1'b0);
        chk("reset id_valid", id_valid, 1'b0);
        chk("reset id_instr", id_instr, 32'h0);
        chk("reset id_pc", id_pc, 64'h0);

        // ---------------- basic flow, 1-cycle memory ----------------
        addVec(1, 1, 64'h0, 0, 11'h0,   64'h0);
        addVec(1, 0, 64'h0, 0, 11'h0,   64'h0);
        addVec(1, 1, 64'h4, 1, 11'h7C2, 64'h0);
        addVec(1, 0, 64'h0, 0, 11'h0,   64'h0);
        addVec(1, 1, 64'h8, 1, 11'h458, 64'h4);
        addVec(1, 0, 64'h0, 0, 11'h0,   64'h0);
        addVec(1, 1, 64'hC, 1, 11'h002, 64'h8);
        runTable("basic");

        // ---------------- back-pressure into the skid ----------------
        doReset(1);
        addVec(0, 1, 64'h0, 0, 11'h0,   64'h0);
        addVec(0, 0, 64'h0, 0, 11'h0,   64'h0);
        addVec(0, 1, 64'h4, 1, 11'h7C2, 64'h0);
        for (int k = 0; k < 5; k++)
            addVec(0, 0, 64'h0, 1, 11'h7C2, 64'h0);
        addVec(1, 0, 64'h0, 1, 11'h7C2, 64'h0);
        addVec(1, 1, 64'h8, 1, 11'h458, 64'h4);
        addVec(1, 0, 64'h0, 0, 11'h0,   64'h0);
        addVec(1, 1, 64'hC, 1, 11'h002, 64'h8);
        runTable("bp");

        // ---------------- redirect while 0x8 outstanding, 3-cycle memory ----------------
        doReset(3);
        id_ready = 1'b1;
        repeat (8) cyc();                 // cycles 1..8
        cyc(); id_ready = 1'b0; #1;       // cycle 9: fetch of 0x8 issues, pc 4 held
        chk("redir c9 imem_addr", imem_addr, 64'h8);
        chk("redir c9 id_pc", id_pc, 64'h4);
        cyc(); redirect_valid = 1'b1; redirect_pc = 64'h100; #1;   // cycle 10
        chk("redir c10 imem_req", imem_req, 1'b0);
        chk("redir c10 id_valid", id_valid, 1'b1);
        cyc(); redirect_valid = 1'b0; id_ready = 1'b1; #1;         // cycle 11
        chk("redir c11 id_valid", id_valid, 1'b0);
        chk("redir c11 imem_req", imem_req, 1'b0);
        cyc(); #1;                                                  // cycle 12: stale word returns
        chk("redir c12 imem_req", imem_req, 1'b0);
        cyc(); #1;                                                  // cycle 13
        chk("redir c13 id_valid", id_valid, 1'b0);
        chk("redir c13 imem_req", imem_req, 1'b1);
        chk("redir c13 imem_addr", imem_addr, 64'h100);
        for (int k = 14; k <= 16; k++) begin
            cyc(); #1;
            chk($sformatf("redir c%0d id_valid", k), id_valid, 1'b0);
        end
        cyc(); #1;                                                  // cycle 17
        chk("redir c17 id_valid", id_valid, 1'b1);
        chk("redir c17 id_pc", id_pc, 64'h100);
        chk("redir c17 id_op", id_op, 11'h040);

        // ---------------- redirect coincident with imem_rvalid ----------------
        doReset(1);
        id_ready = 1'b1;
        cyc(); #1;                                                  // cycle 1
        chk("coin c1 imem_addr", imem_addr, 64'h0);
        cyc(); redirect_valid = 1'b1; redirect_pc = 64'h200; #1;   // cycle 2, rvalid this cycle
        chk("coin c2 imem_req", imem_req, 1'b0);
        cyc(); redirect_valid = 1'b0; #1;                           // cycle 3
        chk("coin c3 id_valid", id_valid, 1'b0);
        chk("coin c3 imem_req", imem_req, 1'b1);
        chk("coin c3 imem_addr", imem_addr, 64'h200);
        cyc(); #1;                                                  // cycle 4
        chk("coin c4 id_valid", id_valid, 1'b0);
        cyc(); #1;                                                  // cycle 5
        chk("coin c5 id_valid", id_valid, 1'b1);
        chk("coin c5 id_pc", id_pc, 64'h200);
        chk("coin c5 id_instr", id_instr, {11'h080, 21'h0A5A5A});

        // ---------------- async reset with a request outstanding ----------------
        doReset(3);
        repeat (4) cyc();                                           // cycles 1..4
        cyc(); #1;                                                  // cycle 5
        chk("rstmid c5 id_valid", id_valid, 1'b1);
        chk("rstmid c5 imem_addr", imem_addr, 64'h4);
        cyc(); #1;                                                  // cycle 6: 0x4 in flight
        chk("rstmid c6 imem_req", imem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstmid async id_valid", id_valid, 1'b0);
        chk("rstmid async id_instr", id_instr, 32'h0);
        chk("rstmid async id_pc", id_pc, 64'h0);
        chk("rstmid async imem_req", imem_req, 1'b0);
        repeat (3) @(posedge clk);
        cyc(); #1;                                                  // cycle 1 after release
        chk("rstmid r1 imem_req", imem_req, 1'b1);
        chk("rstmid r1 imem_addr", imem_addr, 64'h0);
        for (int k = 2; k <= 4; k++) begin
            cyc(); #1;
            chk($sformatf("rstmid r%0d id_valid", k), id_valid, 1'b0);
        end
        cyc(); #1;                                                  // cycle 5
        chk("rstmid r5 id_pc", id_pc, 64'h0);
        chk("rstmid r5 id_op", id_op, 11'h7C2);

        // ---------------- PC wrap and stray response ----------------
        doReset(2);
        id_ready = 1'b1;
        cyc(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;   // cycle 1
        chk("wrap c1 imem_req", imem_req, 1'b0);
        cyc(); redirect_valid = 1'b0; manRvalid = 1'b1; manRdata = 32'hDEAD_BEEF; #1;  // cycle 2
        chk("wrap c2 imem_req", imem_req, 1'b1);
        chk("wrap c2 imem_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(); manRvalid = 1'b0; #1;                                // cycle 3
        chk("wrap c3 stray id_valid", id_valid, 1'b0);
        cyc(); #1;                                                  // cycle 4
        chk("wrap c4 id_valid", id_valid, 1'b0);
        cyc(); #1;                                                  // cycle 5
        chk("wrap c5 id_valid", id_valid, 1'b1);
        chk("wrap c5 id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap c5 id_op", id_op, 11'h7FF);
        chk("wrap c5 imem_req", imem_req, 1'b1);
        chk("wrap c5 imem_addr", imem_addr, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
